// File: rtl/fwd_hazard_tracker.sv
// fwd_hazard_tracker
//   Tracks in-flight register writes across DEPTH post-decode stages and
//   resolves read-after-write dependences for the decode stage, by
//   forwarding a stage result or, when the value is not produced yet,
//   freezing the front end for a cycle.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   issue_valid   decode presents an instruction
//   issue_wb_en   instruction writes a register
//   issue_dest    destination register of the issuing instruction
//   issue_is_load result is produced by memory
//   flush         branch taken; kill the FLUSH_DEPTH youngest stages
//   src_addr      source register per read port (port k at [k*REG_AW +: REG_AW])
//   src_used      source k is actually read
//   rf_data       register-file read data per port
//   stage_result  result currently held in each tracked stage
//   src_data      resolved operand per port
//   fwd_hit       port k takes a forwarded value
//   hazard        freeze PC, IF/ID and decode; insert a bubble
//   stall_count   saturating count of cycles with hazard
//   fwd_count     saturating count of non-stalled cycles with any forward
module fwd_hazard_tracker #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 4,
  parameter int DEPTH       = 3,
  parameter int NUM_SRC     = 2,
  parameter int LOAD_STAGE  = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int FWD_EN      = 1,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic                        issue_wb_en,
  input  logic [REG_AW-1:0]           issue_dest,
  input  logic                        issue_is_load,
  input  logic                        flush,
  input  logic [NUM_SRC*REG_AW-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]          src_used,
  input  logic [NUM_SRC*DATA_W-1:0]   rf_data,
  input  logic [DEPTH*DATA_W-1:0]     stage_result,
  output logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          fwd_hit,
  output logic                        hazard,
  output logic [CNT_W-1:0]            stall_count,
  output logic [CNT_W-1:0]            fwd_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Tracked stage entries: index 0 is the youngest (EXE).
  logic [DEPTH-1:0]  v_r;
  logic [DEPTH-1:0]  ld_r;
  logic [REG_AW-1:0] dest_r [DEPTH];

  logic [CNT_W-1:0]          stall_cnt_r;
  logic [CNT_W-1:0]          fwd_cnt_r;

  logic [NUM_SRC*DATA_W-1:0] src_data_s;
  logic [NUM_SRC-1:0]        fwd_hit_s;
  logic                      hazard_raw_s;
  logic                      hazard_s;
  logic                      found_s;
  logic                      win_ready_s;
  logic [DATA_W-1:0]         win_data_s;

  // Per-port match search and operand resolution.
  always_comb begin
    src_data_s   = rf_data;
    fwd_hit_s    = {NUM_SRC{1'b0}};
    hazard_raw_s = 1'b0;
    found_s      = 1'b0;
    win_ready_s  = 1'b0;
    win_data_s   = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      found_s     = 1'b0;
      win_ready_s = 1'b0;
      win_data_s  = {DATA_W{1'b0}};
      // Scan oldest to youngest so the youngest match overwrites older ones.
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (src_used[k] && v_r[i] && (dest_r[i] == src_addr[k*REG_AW +: REG_AW])) begin
          found_s     = 1'b1;
          win_ready_s = !ld_r[i] || (i >= LOAD_STAGE);
          win_data_s  = stage_result[i*DATA_W +: DATA_W];
        end else begin
          found_s     = found_s;
        end
      end
      if (found_s) begin
        if (FWD_EN != 0) begin
          if (win_ready_s) begin
            fwd_hit_s[k]                     = 1'b1;
            src_data_s[k*DATA_W +: DATA_W]   = win_data_s;
          end else begin
            hazard_raw_s = 1'b1;
          end
        end else begin
          hazard_raw_s = 1'b1;
        end
      end else begin
        fwd_hit_s[k] = 1'b0;
      end
    end
    // An empty decode slot never needs to stall.
    hazard_s = hazard_raw_s & issue_valid;
  end

  // Stage shift, issue/flush insertion and saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_r         <= {DEPTH{1'b0}};
      ld_r        <= {DEPTH{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      fwd_cnt_r   <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        dest_r[i] <= {REG_AW{1'b0}};
      end
    end else begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        if (flush && (i < FLUSH_DEPTH)) begin
          v_r[i] <= 1'b0;
        end else begin
          v_r[i] <= v_r[i-1];
        end
        dest_r[i] <= dest_r[i-1];
        ld_r[i]   <= ld_r[i-1];
      end
      // Flush beats hazard for the youngest slot; both give a bubble.
      v_r[0]    <= issue_valid & issue_wb_en & ~hazard_s & ~flush;
      dest_r[0] <= issue_dest;
      ld_r[0]   <= issue_is_load;

      if (hazard_s && !(&stall_cnt_r)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if ((|fwd_hit_s) && !hazard_s && !(&fwd_cnt_r)) begin
        fwd_cnt_r <= fwd_cnt_r + CNT_ONE;
      end
    end
  end

  assign src_data    = src_data_s;
  assign fwd_hit     = fwd_hit_s;
  assign hazard      = hazard_s;
  assign stall_count = stall_cnt_r;
  assign fwd_count   = fwd_cnt_r;

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
module tb_fwd_hazard_tracker;

  localparam logic [31:0] RF0 = 32'hF0F0_0000;
  localparam logic [31:0] RF1 = 32'h0B0B_0001;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_wb_en;
  logic [3:0]  issue_dest;
  logic        issue_is_load;
  logic        flush;
  logic [7:0]  src_addr;
  logic [1:0]  src_used;
  logic [63:0] rf_data;
  logic [95:0] stage_result;

  logic [63:0] src_data;
  logic [1:0]  fwd_hit;
  logic        hazard;
  logic [15:0] stall_count;
  logic [15:0] fwd_count;

  logic [63:0] src_data2;
  logic [1:0]  fwd_hit2;
  logic        hazard2;
  logic [1:0]  stall_count2;
  logic [1:0]  fwd_count2;

  int n_checks;
  int n_fails;

  fwd_hazard_tracker dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_dest(issue_dest), .issue_is_load(issue_is_load),
    .flush(flush), .src_addr(src_addr), .src_used(src_used),
    .rf_data(rf_data), .stage_result(stage_result),
    .src_data(src_data), .fwd_hit(fwd_hit), .hazard(hazard),
    .stall_count(stall_count), .fwd_count(fwd_count)
  );

  fwd_hazard_tracker #(.FWD_EN(0), .CNT_W(2)) dut_nofwd (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_dest(issue_dest), .issue_is_load(issue_is_load),
    .flush(flush), .src_addr(src_addr), .src_used(src_used),
    .rf_data(rf_data), .stage_result(stage_result),
    .src_data(src_data2), .fwd_hit(fwd_hit2), .hazard(hazard2),
    .stall_count(stall_count2), .fwd_count(fwd_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wb, input logic [3:0] dest, input logic ld);
    issue_valid   = 1'b1;
    issue_wb_en   = wb;
    issue_dest    = dest;
    issue_is_load = ld;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0;
    issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = 4'd0; issue_is_load = 1'b0;
    flush = 1'b0; src_addr = 8'h00; src_used = 2'b00;
    rf_data = {RF1, RF0};
    stage_result = 96'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hazard", {63'd0, hazard}, 64'd0);
    chk("rst_fwd_hit", {62'd0, fwd_hit}, 64'd0);
    chk("rst_src_data", src_data, {RF1, RF0});
    chk("rst_stall", {48'd0, stall_count}, 64'd0);
    chk("rst_fwdcnt", {48'd0, fwd_count}, 64'd0);
    rst = 1'b1;
    tick();

    // ALU-use forwarding from EXE
    issue(1'b1, 4'd3, 1'b0);
    tick();
    issue(1'b0, 4'd0, 1'b0);
    src_addr = 8'h03; src_used = 2'b01;
    stage_result = {32'h0, 32'h0, 32'h0000_00AA};
    #1;
    chk("alu_fwd_hit", {62'd0, fwd_hit}, 64'd1);
    chk("alu_src0", {32'd0, src_data[31:0]}, 64'h0000_00AA);
    chk("alu_src1", {32'd0, src_data[63:32]}, {32'd0, RF1});
    chk("alu_hazard", {63'd0, hazard}, 64'd0);
    tick();
    chk("alu_fwdcnt", {48'd0, fwd_count}, 64'd1);

    // Load-use: one stall cycle, then forward from MEM
    src_used = 2'b00;
    issue(1'b1, 4'd2, 1'b1);
    tick();
    issue(1'b0, 4'd0, 1'b0);
    src_addr = 8'h20; src_used = 2'b10;
    stage_result = {32'h0, 32'h0000_BEEF, 32'h0000_DEAD};
    #1;
    chk("ld_hazard", {63'd0, hazard}, 64'd1);
    chk("ld_fwd_hit_stall", {62'd0, fwd_hit}, 64'd0);
    chk("ld_src1_stall", {32'd0, src_data[63:32]}, {32'd0, RF1});
    issue_valid = 1'b0;
    #1;
    chk("ld_hazard_gated", {63'd0, hazard}, 64'd0);
    issue_valid = 1'b1;
    #1;
    tick();
    chk("ld_hazard_clear", {63'd0, hazard}, 64'd0);
    chk("ld_fwd_hit_mem", {62'd0, fwd_hit}, 64'd2);
    chk("ld_src1_mem", {32'd0, src_data[63:32]}, 64'h0000_BEEF);
    chk("ld_stall_cnt", {48'd0, stall_count}, 64'd1);
    tick();
    chk("ld_fwdcnt", {48'd0, fwd_count}, 64'd2);

    // Priority: R5 in stage 2 and stage 0, youngest wins
    src_used = 2'b00;
    issue(1'b1, 4'd5, 1'b0);
    tick();
    issue(1'b0, 4'd0, 1'b0);
    tick();
    issue(1'b1, 4'd5, 1'b0);
    tick();
    issue(1'b0, 4'd0, 1'b0);
    src_addr = 8'h05; src_used = 2'b01;
    stage_result = {32'h0000_0011, 32'h0000_0099, 32'h0000_0022};
    #1;
    chk("prio_src0", {32'd0, src_data[31:0]}, 64'h0000_0022);
    chk("prio_fwd_hit", {62'd0, fwd_hit}, 64'd1);
    tick();

    // Flush: R4 killed in EXE, R5 now in MEM shifts into WB and survives
    src_used = 2'b00;
    issue(1'b1, 4'd4, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue(1'b0, 4'd0, 1'b0);
    src_addr = 8'h54; src_used = 2'b11;
    stage_result = {32'h0000_0077, 32'h0000_0066, 32'h0000_0055};
    #1;
    chk("flush_fwd_hit", {62'd0, fwd_hit}, 64'd2);
    chk("flush_src0", {32'd0, src_data[31:0]}, {32'd0, RF0});
    chk("flush_src1", {32'd0, src_data[63:32]}, 64'h0000_0077);
    chk("flush_hazard", {63'd0, hazard}, 64'd0);
    tick();

    // Reset mid-operation with all three entries full
    src_used = 2'b00;
    issue(1'b1, 4'd6, 1'b0);
    repeat (3) tick();
    issue(1'b0, 4'd0, 1'b0);
    src_addr = 8'h66; src_used = 2'b11;
    #1;
    chk("pre_rst_fwd_hit", {62'd0, fwd_hit}, 64'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_hazard", {63'd0, hazard}, 64'd0);
    chk("mid_rst_fwd_hit", {62'd0, fwd_hit}, 64'd0);
    chk("mid_rst_src_data", src_data, {RF1, RF0});
    chk("mid_rst_stall", {48'd0, stall_count}, 64'd0);
    chk("mid_rst_fwdcnt", {48'd0, fwd_count}, 64'd0);
    tick();
    rst = 1'b1;
    src_used = 2'b00;
    tick();

    // FWD_EN=0 with 2-bit counters: stall on any match, saturate at 3
    issue(1'b1, 4'd1, 1'b0);
    repeat (3) tick();
    issue(1'b0, 4'd0, 1'b0);
    src_addr = 8'h01; src_used = 2'b01;
    #1;
    chk("nf_hazard", {63'd0, hazard2}, 64'd1);
    chk("nf_fwd_hit", {62'd0, fwd_hit2}, 64'd0);
    chk("nf_src_data", src_data2, {RF1, RF0});
    repeat (3) tick();
    chk("nf_stall_3", {62'd0, stall_count2}, 64'd3);
    chk("nf_hazard_drained", {63'd0, hazard2}, 64'd0);
    src_used = 2'b00;
    issue(1'b1, 4'd1, 1'b0);
    repeat (3) tick();
    issue(1'b0, 4'd0, 1'b0);
    src_used = 2'b01;
    #1;
    chk("nf_hazard_again", {63'd0, hazard2}, 64'd1);
    tick();
    chk("nf_stall_sat", {62'd0, stall_count2}, 64'd3);
    chk("nf_fwdcnt", {62'd0, fwd_count2}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
